fifo_write_logic: RTL and testbench
===================================

Name: fifo_write_logic

Overview:
Ingress write stage for the router input FIFO. It accepts a byte stream with a valid/ready handshake and parses packets framed as source_id, dest_id, size, size payload bytes, then crc. It allocates a free packet slot and writes each byte into fifo_memory through its write port (write_en/waddr/waddr_in/wdata). On a good crc it commits the slot to fifo_read_logic and returns the slot to the free pool when read logic releases it.

Parameters:
PTR_SZ, 2, slot index width (2^PTR_SZ packet slots)
PTR_IN_SZ, 4, byte index width within a slot (2^PTR_IN_SZ bytes per slot)
UWIDTH, 8, byte width
MAX_PAYLOAD, 12, largest legal size field (2^PTR_IN_SZ - 4)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  input byte valid
in_sop  in  1  marks the first byte (source_id) of a packet
in_data  in  UWIDTH  input byte
in_ready  out  1  byte accepted when in_valid & in_ready
write_en  out  1  fifo_memory write strobe
waddr  out  PTR_SZ  slot being written
waddr_in  out  PTR_IN_SZ  byte offset in slot
wdata  out  UWIDTH  write byte
release_en  in  1  read logic has drained a slot
release_addr  in  PTR_SZ  slot being released
slot_full  out  2^PTR_SZ  committed-packet bitmap
pkt_done  out  1  one-cycle commit pulse
pkt_addr  out  PTR_SZ  committed slot, valid with pkt_done
pkt_dest  out  UWIDTH  dest_id of committed packet, valid with pkt_done
drop_err  out  1  one-cycle pulse when a packet is dropped

Behaviour:
- Reset (rst low, asynchronous): FSM goes to IDLE. All outputs are 0, including slot_full. All slot busy/full state clears. Memory contents are don't-care.
- FSM states: IDLE, DST, SIZE, PAYLOAD, CRC, DISCARD.
- IDLE:
  - in_ready = free_slot_avail | ~in_sop.
  - A non-sop byte is consumed and discarded silently.
  - An accepted sop byte allocates the lowest-index slot that is neither busy nor full, stores it as src, and moves to DST.
- DST: accepts dest_id, latches it for pkt_dest, moves to SIZE.
- SIZE:
  - size 1..MAX_PAYLOAD: latch size, move to PAYLOAD.
  - size 0 or size > MAX_PAYLOAD: pulse drop_err, free the slot, move to DISCARD. The size byte is still written.
- PAYLOAD: after accepting size bytes, move to CRC.
- CRC:
  - The accepted byte is compared with the XOR of all prior packet bytes (src through last payload byte).
  - Match: set slot_full[slot], pulse pkt_done with pkt_addr/pkt_dest, go to IDLE.
  - Mismatch: pulse drop_err, free the slot, go to IDLE.
  - Commit and drop indications come 1 cycle after the crc byte is accepted, the same cycle as the crc write.
- DISCARD: in_ready = ~in_sop. Non-sop bytes are consumed without writes. A valid sop is not accepted; the FSM moves to IDLE next cycle.
- In DST, SIZE, PAYLOAD and CRC, in_ready = ~in_sop.
- sop during DST/SIZE/PAYLOAD/CRC (abort): the sop byte is not accepted. drop_err pulses, the slot is freed, and the FSM moves to IDLE next cycle; IDLE then accepts the sop.
- Write latency: registered, 1 cycle after acceptance.
  - write_en=1, waddr=allocated slot, waddr_in=byte offset (0 src, 1 dst, 2 size, 3.. payload, size+3 crc), wdata=the byte.
  - Every byte accepted in DST through CRC is written, even if the packet is later dropped.
  - waddr_in never wraps, because size is bounded.
- Release:
  - release_en clears slot_full[release_addr] at the next edge.
  - Releasing a slot that is not full is ignored.
  - A slot released in cycle N is allocatable from cycle N+1; allocation uses registered state only.
- Committing and releasing different slots in the same cycle both take effect.
- Back-to-back packets: a sop may be accepted in the cycle after the crc byte.

Decomposition:
- Shared include router_defs.vh holds:
  - PTR_SZ, PTR_IN_SZ and UWIDTH defaults.
  - Header offsets: SRC_IDX=0, DST_IDX=1, SIZE_IDX=2, DATA_IDX=3.
  - FSM state encodings.
- One sub-module, fifo_slot_alloc: per-slot busy/full flags, lowest-index free priority encoder, and allocate/commit/free/release updates.

Test Plan:
1. Good packet: sop packet 10,5,3,0,1,2,15 into an empty block -> 7 writes at waddr=0 with waddr_in 0..6 and wdata echoed; pkt_done with pkt_addr=0 and pkt_dest=5; slot_full=0001.
2. Bad crc: same packet with crc=14 -> 7 writes, drop_err pulse, no pkt_done, slot_full=0000; the next packet again uses slot 0.
3. Full and release: four good packets -> slots 0,1,2,3, slot_full=1111. A fifth sop holds in_ready=0. Pulse release_en with release_addr=2 -> slot_full=1011 next cycle; the sop is accepted the following cycle and writes to waddr=2.
4. Oversize: size byte 13 -> drop_err after the size write, the remaining bytes are consumed with no writes, and the next sop starts a clean packet in slot 0.
5. Abort: sop arrives with the 2nd payload byte -> drop_err, slot freed, the new packet is written to the same slot from waddr_in=0.
6. Reset mid-payload: rst low -> write_en, in_ready, pkt_done and slot_full are all 0 immediately; after rst high, the first packet uses slot 0.

Source files
------------

// File: rtl/fifo_write_logic_pkg.sv
// Shared definitions for the router ingress write stage: geometry, header
// byte offsets, FSM state encoding and the legal-size helper.
package fifo_write_logic_pkg;
  localparam int PTR_SZ      = 2;                     // slot index width
  localparam int PTR_IN_SZ   = 4;                     // byte index width within a slot
  localparam int UWIDTH      = 8;                     // byte width
  localparam int NUM_SLOTS   = 1 << PTR_SZ;
  localparam int MAX_PAYLOAD = (1 << PTR_IN_SZ) - 4;  // header(3) + crc(1) must fit a slot

  localparam logic [PTR_IN_SZ-1:0] SRC_IDX  = 4'd0;
  localparam logic [PTR_IN_SZ-1:0] DST_IDX  = 4'd1;
  localparam logic [PTR_IN_SZ-1:0] SIZE_IDX = 4'd2;
  localparam logic [PTR_IN_SZ-1:0] DATA_IDX = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DST     = 3'd1,
    ST_SIZE    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CRC     = 3'd4,
    ST_DISCARD = 3'd5
  } state_e;

  function automatic logic size_ok(input logic [UWIDTH-1:0] s);
    return (s != '0) && (s <= UWIDTH'(MAX_PAYLOAD));
  endfunction
endpackage

// File: rtl/fifo_write_logic_if.sv
// Ingress byte stream, fifo_memory write port and read-logic commit/release
// signals. slave = write stage, master = its environment.
interface fifo_write_logic_if;
  import fifo_write_logic_pkg::*;
  logic                  in_valid;
  logic                  in_sop;
  logic [UWIDTH-1:0]     in_data;
  logic                  in_ready;
  logic                  write_en;
  logic [PTR_SZ-1:0]     waddr;
  logic [PTR_IN_SZ-1:0]  waddr_in;
  logic [UWIDTH-1:0]     wdata;
  logic                  release_en;
  logic [PTR_SZ-1:0]     release_addr;
  logic [NUM_SLOTS-1:0]  slot_full;
  logic                  pkt_done;
  logic [PTR_SZ-1:0]     pkt_addr;
  logic [UWIDTH-1:0]     pkt_dest;
  logic                  drop_err;

  modport slave (
    input  in_valid, in_sop, in_data, release_en, release_addr,
    output in_ready, write_en, waddr, waddr_in, wdata, slot_full,
           pkt_done, pkt_addr, pkt_dest, drop_err
  );
  modport master (
    output in_valid, in_sop, in_data, release_en, release_addr,
    input  in_ready, write_en, waddr, waddr_in, wdata, slot_full,
           pkt_done, pkt_addr, pkt_dest, drop_err
  );
endinterface

// File: rtl/fifo_write_logic_slot_alloc.sv
// Slot bookkeeping: per-slot busy (being written) and full (committed) flags,
// lowest-index free-slot encoder, allocate/commit/free/release updates.
// Ports: i_alloc takes o_free_idx; i_commit/i_free act on i_slot;
// i_rel_en/i_rel_addr clear a committed slot; o_slot_full is the full bitmap.
module fifo_slot_alloc
  import fifo_write_logic_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_alloc,
  input  logic                 i_commit,
  input  logic                 i_free,
  input  logic [PTR_SZ-1:0]    i_slot,
  input  logic                 i_rel_en,
  input  logic [PTR_SZ-1:0]    i_rel_addr,
  output logic                 o_free_avail,
  output logic [PTR_SZ-1:0]    o_free_idx,
  output logic [NUM_SLOTS-1:0] o_slot_full
);
  logic [NUM_SLOTS-1:0] r_busy, r_full;
  logic [NUM_SLOTS-1:0] w_free;

  // Allocation looks only at registered flags, so a release becomes
  // visible to the encoder one cycle later.
  assign w_free       = ~(r_busy | r_full);
  assign o_free_avail = |w_free;
  assign o_slot_full  = r_full;

  always_comb begin
    o_free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (w_free[i]) o_free_idx = PTR_SZ'(i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      r_full <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (i_alloc && o_free_idx == PTR_SZ'(i))                r_busy[i] <= 1'b1;
        if ((i_commit || i_free) && i_slot == PTR_SZ'(i))       r_busy[i] <= 1'b0;
        // Commit and release never target the same slot: the slot being
        // committed is not full yet, so a release of it is a no-op anyway.
        if (i_commit && i_slot == PTR_SZ'(i))                   r_full[i] <= 1'b1;
        else if (i_rel_en && i_rel_addr == PTR_SZ'(i))          r_full[i] <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/fifo_write_logic.sv
// Router input FIFO write stage. Parses src/dst/size/payload/crc packets from
// a valid/ready byte stream, writes every byte into its allocated slot one
// cycle after acceptance, and commits the slot on a good crc.
// Ports: clk, rst (async active-low), bus (slave modport: stream in,
// memory write port, commit/drop/release signals).
module fifo_write_logic
  import fifo_write_logic_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fifo_write_logic_if.slave  bus
);
  state_e                 r_state, w_nxt_state;
  logic                   w_in_ready, w_wr, w_alloc, w_commit, w_free, w_drop;
  logic [PTR_IN_SZ-1:0]   w_off, w_last;
  logic                   w_free_avail;
  logic [PTR_SZ-1:0]      w_free_idx;
  logic [NUM_SLOTS-1:0]   w_slot_full;

  logic [PTR_SZ-1:0]      r_slot, r_waddr, r_pkt_addr;
  logic [UWIDTH-1:0]      r_dest, r_crc, r_wdata, r_pkt_dest;
  logic [PTR_IN_SZ-1:0]   r_size, r_cnt, r_waddr_in;
  logic                   r_write_en, r_pkt_done, r_drop_err;

  // Offset of the last payload byte; r_cnt tracks the next offset to write.
  assign w_last = r_size + (DATA_IDX - 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_in_ready  = 1'b0;
    w_wr        = 1'b0;
    w_alloc     = 1'b0;
    w_commit    = 1'b0;
    w_free      = 1'b0;
    w_drop      = 1'b0;
    w_off       = SRC_IDX;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = w_free_avail | ~bus.in_sop;
        if (bus.in_valid && bus.in_sop && w_free_avail) begin
          w_alloc     = 1'b1;
          w_wr        = 1'b1;
          w_nxt_state = ST_DST;
        end
      end
      ST_DISCARD: begin
        w_in_ready = ~bus.in_sop;
        if (bus.in_valid && bus.in_sop) w_nxt_state = ST_IDLE;
      end
      ST_DST, ST_SIZE, ST_PAYLOAD, ST_CRC: begin
        w_in_ready = ~bus.in_sop;
        if (bus.in_valid && bus.in_sop) begin
          // Abort: sop is held off one cycle so IDLE can allocate cleanly.
          w_drop      = 1'b1;
          w_free      = 1'b1;
          w_nxt_state = ST_IDLE;
        end else if (bus.in_valid) begin
          w_wr = 1'b1;
          case (r_state)
            ST_DST: begin
              w_off       = DST_IDX;
              w_nxt_state = ST_SIZE;
            end
            ST_SIZE: begin
              w_off = SIZE_IDX;
              if (size_ok(bus.in_data)) begin
                w_nxt_state = ST_PAYLOAD;
              end else begin
                w_drop      = 1'b1;
                w_free      = 1'b1;
                w_nxt_state = ST_DISCARD;
              end
            end
            ST_PAYLOAD: begin
              w_off = r_cnt;
              if (r_cnt == w_last) w_nxt_state = ST_CRC;
            end
            default: begin  // ST_CRC
              w_off = r_cnt;
              if (bus.in_data == r_crc) w_commit = 1'b1;
              else begin
                w_drop = 1'b1;
                w_free = 1'b1;
              end
              w_nxt_state = ST_IDLE;
            end
          endcase
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot     <= '0;
      r_dest     <= '0;
      r_size     <= '0;
      r_cnt      <= '0;
      r_crc      <= '0;
      r_write_en <= 1'b0;
      r_waddr    <= '0;
      r_waddr_in <= '0;
      r_wdata    <= '0;
      r_pkt_done <= 1'b0;
      r_pkt_addr <= '0;
      r_pkt_dest <= '0;
      r_drop_err <= 1'b0;
    end else begin
      r_write_en <= w_wr;
      if (w_wr) begin
        r_waddr    <= w_alloc ? w_free_idx : r_slot;
        r_waddr_in <= w_off;
        r_wdata    <= bus.in_data;
      end
      if (w_alloc) begin
        r_slot <= w_free_idx;
        r_crc  <= bus.in_data;
      end else if (w_wr) begin
        r_crc  <= r_crc ^ bus.in_data;
      end
      if (w_wr && r_state == ST_DST) r_dest <= bus.in_data;
      if (w_wr && r_state == ST_SIZE) begin
        r_size <= bus.in_data[PTR_IN_SZ-1:0];
        r_cnt  <= DATA_IDX;
      end else if (w_wr && r_state == ST_PAYLOAD) begin
        r_cnt  <= r_cnt + 4'd1;
      end
      r_pkt_done <= w_commit;
      if (w_commit) begin
        r_pkt_addr <= r_slot;
        r_pkt_dest <= r_dest;
      end
      r_drop_err <= w_drop;
    end
  end

  fifo_slot_alloc u_alloc (
    .clk          (clk),
    .rst          (rst),
    .i_alloc      (w_alloc),
    .i_commit     (w_commit),
    .i_free       (w_free),
    .i_slot       (r_slot),
    .i_rel_en     (bus.release_en),
    .i_rel_addr   (bus.release_addr),
    .o_free_avail (w_free_avail),
    .o_free_idx   (w_free_idx),
    .o_slot_full  (w_slot_full)
  );

  // in_ready is forced low while reset is asserted.
  assign bus.in_ready  = w_in_ready & rst;
  assign bus.write_en  = r_write_en;
  assign bus.waddr     = r_waddr;
  assign bus.waddr_in  = r_waddr_in;
  assign bus.wdata     = r_wdata;
  assign bus.slot_full = w_slot_full;
  assign bus.pkt_done  = r_pkt_done;
  assign bus.pkt_addr  = r_pkt_addr;
  assign bus.pkt_dest  = r_pkt_dest;
  assign bus.drop_err  = r_drop_err;
endmodule

// File: tb/tb_fifo_write_logic.sv
module tb_fifo_write_logic;
  import fifo_write_logic_pkg::*;

  logic clk, rst;
  fifo_write_logic_if bif();
  fifo_write_logic dut (.clk(clk), .rst(rst), .bus(bif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: packet-position view ----------------
  int        m_full;          // committed bitmap
  int        m_slot;          // slot of packet in progress, -1 if none
  int        m_cur[$];        // bytes of the packet received so far
  int        m_disc;          // discarding the rest of a bad-size packet
  int        e_we, e_waddr, e_off, e_wdata, e_done, e_addr, e_dest, e_drop;

  function automatic void m_reset();
    m_full = 0; m_slot = -1; m_cur = {}; m_disc = 0;
  endfunction

  function automatic int m_lowest_free();
    for (int i = 0; i < NUM_SLOTS; i++) if (!m_full[i]) return i;
    return -1;
  endfunction

  function automatic int m_ready(input int s);
    if (m_disc != 0 || m_slot >= 0) return (s == 0) ? 1 : 0;
    return (m_full != 15 || s == 0) ? 1 : 0;
  endfunction

  function automatic void m_step(input int v, input int s, input int d, input int re, input int ra);
    int nf, off, x;
    nf = m_full;
    e_we = 0; e_done = 0; e_drop = 0; e_waddr = 0; e_off = 0; e_wdata = 0; e_addr = 0; e_dest = 0;
    if (re != 0) nf[ra] = 1'b0;
    if (v != 0) begin
      if (m_disc != 0) begin
        if (s != 0) m_disc = 0;
      end else if (m_slot < 0) begin
        if (s != 0 && m_ready(s) != 0) begin
          m_slot = m_lowest_free();
          m_cur = {d};
          e_we = 1; e_waddr = m_slot; e_off = 0; e_wdata = d;
        end
      end else if (s != 0) begin
        e_drop = 1; m_slot = -1; m_cur = {};
      end else begin
        off = m_cur.size();
        e_we = 1; e_waddr = m_slot; e_off = off; e_wdata = d;
        if (off == 2 && (d == 0 || d > MAX_PAYLOAD)) begin
          e_drop = 1; m_slot = -1; m_cur = {}; m_disc = 1;
        end else if (off >= 3 && off == m_cur[2] + 3) begin
          x = 0;
          foreach (m_cur[i]) x = x ^ m_cur[i];
          if (x == d) begin
            e_done = 1; e_addr = m_slot; e_dest = m_cur[1]; nf[m_slot] = 1'b1;
          end else e_drop = 1;
          m_slot = -1; m_cur = {};
        end else m_cur.push_back(d);
      end
    end
    m_full = nf;
  endfunction

  // ---------------- drivers ----------------
  int g_rdy;

  task automatic drive(input int v, input int s, input int d, input int re, input int ra);
    bif.in_valid     = 1'(v);
    bif.in_sop       = 1'(s);
    bif.in_data      = 8'(d);
    bif.release_en   = 1'(re);
    bif.release_addr = 2'(ra);
    #4;
    g_rdy = int'(bif.in_ready);
    chk("model_in_ready", 32'(g_rdy), 32'(m_ready(s)));
    m_step(v, s, d, re, ra);
    @(posedge clk);
    #1;
    chk("model_write_en", 32'(bif.write_en), 32'(e_we));
    chk("model_slot_full", 32'(bif.slot_full), 32'(m_full));
    chk("model_pkt_done", 32'(bif.pkt_done), 32'(e_done));
    chk("model_drop_err", 32'(bif.drop_err), 32'(e_drop));
    if (e_we != 0) begin
      chk("model_waddr", 32'(bif.waddr), 32'(e_waddr));
      chk("model_waddr_in", 32'(bif.waddr_in), 32'(e_off));
      chk("model_wdata", 32'(bif.wdata), 32'(e_wdata));
    end
    if (e_done != 0) begin
      chk("model_pkt_addr", 32'(bif.pkt_addr), 32'(e_addr));
      chk("model_pkt_dest", 32'(bif.pkt_dest), 32'(e_dest));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bif.in_valid = 1'b0; bif.in_sop = 1'b0; bif.in_data = '0;
    bif.release_en = 1'b0; bif.release_addr = '0;
    #2;
    chk("rst_in_ready", 32'(bif.in_ready), 0);
    chk("rst_write_en", 32'(bif.write_en), 0);
    chk("rst_slot_full", 32'(bif.slot_full), 0);
    chk("rst_pkt_done", 32'(bif.pkt_done), 0);
    chk("rst_drop_err", 32'(bif.drop_err), 0);
    chk("rst_waddr", 32'({bif.waddr, bif.waddr_in, bif.wdata}), 0);
    chk("rst_pkt_info", 32'({bif.pkt_addr, bif.pkt_dest}), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_reset();
  endtask

  typedef int bq_t[$];

  function automatic bq_t mk_pkt(input int src, input int dst, input int size, input int bad);
    bq_t q;
    int x;
    q = {src, dst, size};
    for (int i = 0; i < size; i++) q.push_back(int'($urandom_range(0, 255)));
    x = 0;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(bad != 0 ? (x ^ 1) : x);
    return q;
  endfunction

  int g_first_waddr;

  task automatic send(input bq_t b);
    int tries;
    foreach (b[i]) begin
      tries = 0;
      do begin
        drive(1, (i == 0) ? 1 : 0, b[i], 0, 0);
        tries++;
      end while (g_rdy == 0 && tries < 50);
      if (g_rdy == 0) chk("send_timeout", 32'(tries), 0);
      if (i == 0) g_first_waddr = int'(bif.waddr);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int v, s, d, re, ra;
    int rdy, we, waddr, off, done, dest, drop, full;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int v, input int s, input int d, input int re, input int ra,
                              input int rdy, input int we, input int waddr, input int off,
                              input int done, input int dest, input int drop, input int full);
    vec_t t;
    t = '{v, s, d, re, ra, rdy, we, waddr, off, done, dest, drop, full};
    tbl.push_back(t);
  endfunction

  int stream[$];   // {sop, data} as sop*256 + data

  initial begin
    int v, s, d, re, ra, r, len;
    bq_t p;
    rst = 1'b1;
    #1;
    do_reset();

    // Good packet, release, bad-crc packet, then the slot is reused.
    add(1,0,77, 0,0, 1,0,0,0, 0,0,0,0);
    add(1,1,10, 0,0, 1,1,0,0, 0,0,0,0);
    add(1,0,5,  0,0, 1,1,0,1, 0,0,0,0);
    add(1,0,3,  0,0, 1,1,0,2, 0,0,0,0);
    add(1,0,0,  0,0, 1,1,0,3, 0,0,0,0);
    add(1,0,1,  0,0, 1,1,0,4, 0,0,0,0);
    add(1,0,2,  0,0, 1,1,0,5, 0,0,0,0);
    add(1,0,15, 0,0, 1,1,0,6, 1,5,0,1);
    add(0,0,0,  1,0, 1,0,0,0, 0,0,0,0);
    add(1,1,10, 0,0, 1,1,0,0, 0,0,0,0);
    add(1,0,5,  0,0, 1,1,0,1, 0,0,0,0);
    add(1,0,3,  0,0, 1,1,0,2, 0,0,0,0);
    add(1,0,0,  0,0, 1,1,0,3, 0,0,0,0);
    add(1,0,1,  0,0, 1,1,0,4, 0,0,0,0);
    add(1,0,2,  0,0, 1,1,0,5, 0,0,0,0);
    add(1,0,14, 0,0, 1,1,0,6, 0,0,1,0);
    add(1,1,10, 0,0, 1,1,0,0, 0,0,0,0);
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].re, tbl[i].ra);
      chk("tbl_in_ready", 32'(g_rdy), 32'(tbl[i].rdy));
      chk("tbl_write_en", 32'(bif.write_en), 32'(tbl[i].we));
      chk("tbl_slot_full", 32'(bif.slot_full), 32'(tbl[i].full));
      chk("tbl_pkt_done", 32'(bif.pkt_done), 32'(tbl[i].done));
      chk("tbl_drop_err", 32'(bif.drop_err), 32'(tbl[i].drop));
      if (tbl[i].we != 0) begin
        chk("tbl_waddr", 32'(bif.waddr), 32'(tbl[i].waddr));
        chk("tbl_waddr_in", 32'(bif.waddr_in), 32'(tbl[i].off));
        chk("tbl_wdata", 32'(bif.wdata), 32'(tbl[i].d));
      end
      if (tbl[i].done != 0) chk("tbl_pkt_dest", 32'(bif.pkt_dest), 32'(tbl[i].dest));
    end

    // Fill all slots, stall a sop, release slot 2, sop lands in slot 2.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(mk_pkt(i, 20 + i, 1 + i, 0));
      chk("fill_slot", 32'(g_first_waddr), 32'(i));
    end
    chk("fill_full", 32'(bif.slot_full), 32'hF);
    drive(1, 1, 40, 0, 0);
    chk("full_stall", 32'(g_rdy), 0);
    drive(1, 1, 40, 1, 2);
    chk("rel_stall", 32'(g_rdy), 0);
    chk("rel_full", 32'(bif.slot_full), 32'b1011);
    drive(1, 1, 40, 0, 0);
    chk("rel_accept", 32'(g_rdy), 1);
    chk("rel_waddr", 32'(bif.waddr), 2);

    // Oversize packet: size byte written, rest dropped silently.
    do_reset();
    drive(1, 1, 1, 0, 0);
    drive(1, 0, 2, 0, 0);
    drive(1, 0, 13, 0, 0);
    chk("ovs_drop", 32'(bif.drop_err), 1);
    chk("ovs_size_wr", 32'(bif.waddr_in), 2);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 50 + i, 0, 0);
      chk("ovs_no_wr", 32'(bif.write_en), 0);
    end
    drive(1, 1, 7, 0, 0);
    chk("ovs_sop_held", 32'(g_rdy), 0);
    drive(1, 1, 7, 0, 0);
    chk("ovs_new_slot", 32'({bif.write_en, bif.waddr, bif.waddr_in}), 32'({1'b1, 2'd0, 4'd0}));

    // Abort on the second payload byte.
    do_reset();
    drive(1, 1, 9, 0, 0);
    drive(1, 0, 7, 0, 0);
    drive(1, 0, 4, 0, 0);
    drive(1, 0, 1, 0, 0);
    drive(1, 1, 20, 0, 0);
    chk("abort_drop", 32'(bif.drop_err), 1);
    chk("abort_no_wr", 32'(bif.write_en), 0);
    drive(1, 1, 20, 0, 0);
    chk("abort_reuse", 32'({bif.write_en, bif.waddr, bif.waddr_in}), 32'({1'b1, 2'd0, 4'd0}));

    // Reset in the middle of a payload.
    do_reset();
    send(mk_pkt(3, 4, 2, 0));
    drive(1, 1, 1, 0, 0);
    drive(1, 0, 2, 0, 0);
    drive(1, 0, 5, 0, 0);
    drive(1, 0, 7, 0, 0);
    bif.in_valid = 1'b1; bif.in_sop = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bif.write_en), 0);
    chk("mid_rst_rdy", 32'(bif.in_ready), 0);
    chk("mid_rst_done", 32'(bif.pkt_done), 0);
    chk("mid_rst_full", 32'(bif.slot_full), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_reset();
    send(mk_pkt(8, 9, 3, 0));
    chk("post_rst_slot", 32'(g_first_waddr), 0);

    // Random traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (stream.size() == 0) begin
        r = int'($urandom_range(0, 9));
        if (r <= 5 || r == 6) begin
          p = mk_pkt(int'($urandom_range(0,255)), int'($urandom_range(0,255)),
                     int'($urandom_range(1, MAX_PAYLOAD)), (r == 6) ? 1 : 0);
        end else if (r == 7) begin
          p = {int'($urandom_range(0,255)), int'($urandom_range(0,255)),
               ($urandom_range(0,1) != 0) ? 0 : int'($urandom_range(13,255))};
          len = int'($urandom_range(0, 4));
          for (int i = 0; i < len; i++) p.push_back(int'($urandom_range(0,255)));
        end else if (r == 8) begin
          p = mk_pkt(1, 2, int'($urandom_range(1, MAX_PAYLOAD)), 0);
          len = int'($urandom_range(1, p.size() - 1));
          while (p.size() > len) void'(p.pop_back());
        end else begin
          p = {};
          len = int'($urandom_range(1, 3));
          for (int i = 0; i < len; i++) p.push_back(int'($urandom_range(0,255)));
        end
        foreach (p[i]) stream.push_back(((r != 9 && i == 0) ? 256 : 0) + p[i]);
      end
      v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      s  = stream[0] / 256;
      d  = stream[0] % 256;
      re = ($urandom_range(0, 4) == 0) ? 1 : 0;
      ra = int'($urandom_range(0, 3));
      drive(v, s, d, re, ra);
      if (v != 0 && g_rdy != 0) void'(stream.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
